// File: rtl/tile_draw_scheduler_pkg.sv
// Shared constants, state/mode encodings and tile coordinate type for the board tile draw scheduler.
package tile_draw_scheduler_pkg;

    localparam int unsigned COLS       = 16;
    localparam int unsigned ROWS       = 8;
    localparam int unsigned COL_W      = 4;
    localparam int unsigned ROW_W      = 3;
    localparam int unsigned TILE_SHIFT = 2;
    localparam int unsigned ID_W       = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ADDR_W     = ROW_W + COL_W;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT} state_t;
    typedef enum logic {MODE_FULL, MODE_TILE} mode_t;

    // Packs to the board RAM address {row,col}.
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } tile_t;

    function automatic logic [X_W-1:0] pix_x(input logic [COL_W-1:0] col);
        return X_W'(col) << TILE_SHIFT;
    endfunction

    function automatic logic [Y_W-1:0] pix_y(input logic [ROW_W-1:0] row);
        return Y_W'(row) << TILE_SHIFT;
    endfunction

endpackage

// File: rtl/tile_draw_scheduler_fifo.sv
// Single-tile update queue: synchronous FIFO of tile coordinates with a whole-queue clear.
module tile_draw_scheduler_fifo
    import tile_draw_scheduler_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  clear,
    input  logic  push,
    input  tile_t push_data,
    input  logic  pop,
    output tile_t pop_data,
    output logic  ready,
    output logic  empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    tile_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    // Clear wins over a same-cycle push or pop.
    assign push_ok  = push && ready && !clear;
    assign pop_ok   = pop && !empty && !clear;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tile_draw_scheduler.sv
// Sequences sprite_draw over the board: full-board redraws or queued single-tile updates,
// one fetch/latch/issue/wait pass per tile.
module tile_draw_scheduler
    import tile_draw_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              full_req,
    input  logic              tile_req,
    input  logic [COL_W-1:0]  tile_col,
    input  logic [ROW_W-1:0]  tile_row,
    output logic              tile_req_ready,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [ID_W-1:0]   map_rdata,
    output logic [X_W-1:0]    spr_x,
    output logic [Y_W-1:0]    spr_y,
    output logic [ID_W-1:0]   spr_id,
    output logic              spr_begin,
    input  logic              spr_done,
    output logic              busy,
    output logic              frame_done
);

    state_t state;
    mode_t  mode;
    tile_t  cur;
    tile_t  cur_adv;
    tile_t  req_tile;
    tile_t  fifo_head;
    logic   full_pending;
    logic   fifo_empty;
    logic   start_full;
    logic   start_tile;
    logic   last_tile;

    // A full_req seen in IDLE starts immediately; otherwise it is remembered in full_pending.
    assign start_full = (state == S_IDLE) && (full_pending || full_req);
    assign start_tile = (state == S_IDLE) && !start_full && !fifo_empty;
    assign last_tile  = (cur.row == ROW_W'(ROWS - 1)) && (cur.col == COL_W'(COLS - 1));
    assign req_tile   = '{row: tile_row, col: tile_col};

    always_comb begin
        cur_adv = cur;
        if (cur.col == COL_W'(COLS - 1)) begin
            cur_adv.col = '0;
            cur_adv.row = cur.row + ROW_W'(1);
        end else begin
            cur_adv.col = cur.col + COL_W'(1);
        end
    end

    tile_draw_scheduler_fifo u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (start_full),
        .push      (tile_req),
        .push_data (req_tile),
        .pop       (start_tile),
        .pop_data  (fifo_head),
        .ready     (tile_req_ready),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            mode         <= MODE_FULL;
            cur          <= '0;
            full_pending <= 1'b0;
            map_addr     <= '0;
            spr_x        <= '0;
            spr_y        <= '0;
            spr_id       <= '0;
            spr_begin    <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            spr_begin  <= 1'b0;
            frame_done <= 1'b0;
            if (start_full) begin
                full_pending <= 1'b0;
            end else if (full_req) begin
                full_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_full) begin
                        mode     <= MODE_FULL;
                        cur      <= '0;
                        map_addr <= '0;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end else if (start_tile) begin
                        mode     <= MODE_TILE;
                        cur      <= fifo_head;
                        map_addr <= fifo_head;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    spr_id    <= map_rdata;
                    spr_x     <= pix_x(cur.col);
                    spr_y     <= pix_y(cur.row);
                    spr_begin <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (spr_done) begin
                        if (mode == MODE_TILE || last_tile) begin
                            frame_done <= (mode == MODE_FULL);
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            cur      <= cur_adv;
                            map_addr <= cur_adv;
                            state    <= S_FETCH;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Directed bench for tile_draw_scheduler: board RAM model, auto-responding sprite_draw stub,
// a single-tile vector table and hand-written multi-cycle sequences.
module tb_tile_draw_scheduler;

    typedef struct {
        logic [3:0] col;
        logic [2:0] row;
        logic [3:0] rdata;
        int         exp_x;
        int         exp_y;
        int         exp_id;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       full_req;
    logic       tile_req;
    logic [3:0] tile_col;
    logic [2:0] tile_row;
    logic       tile_req_ready;
    logic [6:0] map_addr;
    logic [3:0] map_rdata;
    logic [7:0] spr_x;
    logic [6:0] spr_y;
    logic [3:0] spr_id;
    logic       spr_begin;
    logic       spr_done;
    logic       busy;
    logic       frame_done;

    logic       done_auto = 1'b0;
    logic       done_man  = 1'b0;
    logic       auto_en   = 1'b0;
    logic       outstanding = 1'b0;
    int         cd = 0;
    int         fcnt = 0;
    int         dbl = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] mem [128];
    int         bx[$];
    int         by[$];
    int         bid[$];
    vec_t       vecs[6];

    always #5 clk = ~clk;

    assign spr_done = done_auto | done_man;

    tile_draw_scheduler dut (
        .clk            (clk),
        .resetn         (resetn),
        .full_req       (full_req),
        .tile_req       (tile_req),
        .tile_col       (tile_col),
        .tile_row       (tile_row),
        .tile_req_ready (tile_req_ready),
        .map_addr       (map_addr),
        .map_rdata      (map_rdata),
        .spr_x          (spr_x),
        .spr_y          (spr_y),
        .spr_id         (spr_id),
        .spr_begin      (spr_begin),
        .spr_done       (spr_done),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    // Board RAM: data valid one cycle after the address.
    always @(posedge clk) map_rdata <= mem[map_addr];

    // sprite_draw stub: done pulse a fixed number of cycles after each begin.
    always @(posedge clk) begin
        #2;
        done_auto = 1'b0;
        if (!resetn) begin
            cd = 0;
        end else if (spr_begin && auto_en) begin
            cd = 5;
        end else if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) done_auto = 1'b1;
        end
    end

    // Draw log and protocol watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (!resetn) begin
            outstanding = 1'b0;
        end else begin
            if (spr_begin) begin
                if (outstanding) dbl++;
                outstanding = 1'b1;
                bx.push_back(int'(spr_x));
                by.push_back(int'(spr_y));
                bid.push_back(int'(spr_id));
            end else if (spr_done) begin
                outstanding = 1'b0;
            end
            if (frame_done) fcnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_begins(input int target, input int budget, input string name);
        int k = 0;
        while (bx.size() < target && k < budget) begin
            step(1);
            k++;
        end
        chk({name, "_timeout"}, int'(bx.size() >= target), 1);
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int k = 0;
        while (fcnt < target && k < budget) begin
            step(1);
            k++;
        end
        chk({name, "_timeout"}, int'(fcnt >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    function automatic int gx(input int i);
        return (i < bx.size()) ? bx[i] : -1;
    endfunction

    function automatic int gy(input int i);
        return (i < by.size()) ? by[i] : -1;
    endfunction

    function automatic int gid(input int i);
        return (i < bid.size()) ? bid[i] : -1;
    endfunction

    task automatic push_tile(input logic [3:0] c, input logic [2:0] r);
        tile_col = c;
        tile_row = r;
        tile_req = 1'b1;
        step(1);
        tile_req = 1'b0;
    endtask

    task automatic pulse_full();
        full_req = 1'b1;
        step(1);
        full_req = 1'b0;
    endtask

    initial begin
        int   n0;
        int   n1;
        int   f0;
        int   err;
        int   c;
        int   r;
        logic rd [5];

        vecs[0] = '{4'd3,  3'd5, 4'h2,  12, 20,  2};
        vecs[1] = '{4'd0,  3'd0, 4'hF,   0,  0, 15};
        vecs[2] = '{4'd15, 3'd7, 4'h9,  60, 28,  9};
        vecs[3] = '{4'd15, 3'd0, 4'h1,  60,  0,  1};
        vecs[4] = '{4'd0,  3'd7, 4'hA,   0, 28, 10};
        vecs[5] = '{4'd8,  3'd3, 4'h5,  32, 12,  5};

        for (int a = 0; a < 128; a++) mem[a] = 4'((a * 5 + 3) % 16);
        resetn   = 1'b0;
        full_req = 1'b0;
        tile_req = 1'b0;
        tile_col = '0;
        tile_row = '0;
        step(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(tile_req_ready), 1);
        chk("rst_begin", int'(spr_begin), 0);
        chk("rst_addr", int'(map_addr), 0);
        chk("rst_x", int'(spr_x), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        resetn = 1'b1;
        step(2);

        // Full frame from reset with FETCH/LATCH/ISSUE latency.
        auto_en = 1'b1;
        n0 = bx.size();
        f0 = fcnt;
        pulse_full();
        chk("t1_fetch_busy", int'(busy), 1);
        chk("t1_fetch_addr", int'(map_addr), 0);
        step(1);
        chk("t1_latch_nobegin", int'(spr_begin), 0);
        step(1);
        chk("t1_issue_begin", int'(spr_begin), 1);
        wait_frames(f0 + 1, 3000, "t1_frame");
        step(20);
        chk("t1_draws", bx.size() - n0, 128);
        err = 0;
        for (int k = 0; k < 128; k++) begin
            c = k % 16;
            r = k / 16;
            if (gx(n0 + k) != c * 4 || gy(n0 + k) != r * 4 || gid(n0 + k) != int'(mem[r * 16 + c])) err++;
        end
        chk("t1_order_errors", err, 0);
        chk("t1_last_x", gx(n0 + 127), 60);
        chk("t1_last_y", gy(n0 + 127), 28);
        chk("t1_frames", fcnt - f0, 1);
        chk("t1_busy_after", int'(busy), 0);

        // Single-tile vector table.
        for (int i = 0; i < 6; i++) begin
            n0 = bx.size();
            f0 = fcnt;
            mem[{vecs[i].row, vecs[i].col}] = vecs[i].rdata;
            push_tile(vecs[i].col, vecs[i].row);
            wait_begins(n0 + 1, 30, $sformatf("tv%0d_begin", i));
            chk($sformatf("tv%0d_x", i), gx(n0), vecs[i].exp_x);
            chk($sformatf("tv%0d_y", i), gy(n0), vecs[i].exp_y);
            chk($sformatf("tv%0d_id", i), gid(n0), vecs[i].exp_id);
            wait_idle(40, $sformatf("tv%0d", i));
            step(5);
            chk($sformatf("tv%0d_draws", i), bx.size() - n0, 1);
            chk($sformatf("tv%0d_no_frame_done", i), fcnt - f0, 0);
        end

        // Queue overflow: five back-to-back pushes while a draw is outstanding.
        auto_en = 1'b0;
        n0 = bx.size();
        push_tile(4'd1, 3'd1);
        wait_begins(n0 + 1, 30, "t3_first");
        for (int i = 0; i < 5; i++) begin
            rd[i]    = tile_req_ready;
            tile_col = 4'(4 + i);
            tile_row = 3'd2;
            tile_req = 1'b1;
            step(1);
        end
        tile_req = 1'b0;
        for (int i = 0; i < 5; i++) chk($sformatf("t3_ready%0d", i), int'(rd[i]), (i < 4) ? 1 : 0);
        done_man = 1'b1;
        auto_en  = 1'b1;
        step(1);
        done_man = 1'b0;
        wait_begins(n0 + 5, 200, "t3_queued");
        wait_idle(40, "t3");
        step(40);
        chk("t3_draws", bx.size() - n0, 5);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), gx(n0 + 1 + i), (4 + i) * 4);
        chk("t3_ready_after", int'(tile_req_ready), 1);

        // Spurious spr_done in IDLE and in FETCH.
        n0 = bx.size();
        done_man = 1'b1;
        step(1);
        done_man = 1'b0;
        step(3);
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_draws", bx.size() - n0, 0);
        auto_en = 1'b0;
        push_tile(4'd9, 3'd4);
        step(1);
        chk("t5_fetch_busy", int'(busy), 1);
        done_man = 1'b1;
        step(1);
        done_man = 1'b0;
        wait_begins(n0 + 1, 20, "t5_begin");
        step(15);
        chk("t5_single_begin", bx.size() - n0, 1);
        chk("t5_still_busy", int'(busy), 1);
        done_man = 1'b1;
        step(1);
        done_man = 1'b0;
        wait_idle(10, "t5");

        // Second full_req mid-frame; queued tile discarded at second frame start.
        auto_en = 1'b1;
        n0 = bx.size();
        f0 = fcnt;
        pulse_full();
        wait_begins(n0 + 5, 100, "t4_early");
        push_tile(4'd2, 3'd2);
        wait_begins(n0 + 60, 1000, "t4_tile60");
        pulse_full();
        wait_frames(f0 + 2, 5000, "t4_frames");
        step(40);
        chk("t4_draws", bx.size() - n0, 256);
        chk("t4_frame_count", fcnt - f0, 2);
        chk("t4_f2_first_x", gx(n0 + 128), 0);
        chk("t4_f2_first_y", gy(n0 + 128), 0);
        chk("t4_f2_last_x", gx(n0 + 255), 60);
        chk("t4_f2_last_y", gy(n0 + 255), 28);
        chk("t4_busy_after", int'(busy), 0);

        // Reset while waiting on sprite_draw, with a queued tile.
        n0 = bx.size();
        pulse_full();
        wait_begins(n0 + 20, 400, "t6_run");
        auto_en = 1'b0;
        wait_begins(n0 + 21, 40, "t6_stall");
        step(3);
        push_tile(4'd5, 3'd5);
        resetn = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_begin", int'(spr_begin), 0);
        chk("t6_x", int'(spr_x), 0);
        chk("t6_y", int'(spr_y), 0);
        chk("t6_id", int'(spr_id), 0);
        chk("t6_addr", int'(map_addr), 0);
        chk("t6_ready", int'(tile_req_ready), 1);
        step(2);
        resetn  = 1'b1;
        auto_en = 1'b1;
        n1 = bx.size();
        f0 = fcnt;
        step(30);
        chk("t6_queue_lost", bx.size() - n1, 0);
        chk("t6_no_frame_done", fcnt - f0, 0);
        pulse_full();
        wait_begins(n1 + 1, 20, "t6_restart");
        chk("t6_restart_x", gx(n1), 0);
        chk("t6_restart_y", gy(n1), 0);

        chk("no_double_begin", dbl, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
